// File: rtl/sha256_padder.sv
`timescale 1ns/1ps
// sha256_padder: packs a byte stream (<= 55 bytes) into one padded SHA-256 block and launches sha256_core.
// Optional build macro SHA256_PADDER_TIMEOUT_EN adds a watchdog on the core's completion edge.

package sha256_pkg;
    localparam int BLOCK_SIZE = 256;
endpackage

module sha256_padder
    import sha256_pkg::*;
#(
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_data_i,
    input  logic                    byte_last_i,
    input  logic                    byte_empty_i,
    output logic                    byte_ready_o,
    output logic                    start_o,
    output logic [2*BLOCK_SIZE-1:0] msg_o,
    input  logic                    core_valid_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int         MSG_W      = 2 * BLOCK_SIZE;
    localparam logic [5:0] MAX_BYTES  = 6'd55;
    localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ACCEPT,
        ST_PAD,
        ST_START,
        ST_WAIT,
        ST_DROP,
        ST_CLEAR
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic               err_q, err_d;
    logic [3:0]         start_cnt_q, start_cnt_d;
    logic               valid_prev_q, valid_prev_d;
    logic               core_edge;
    logic               timeout_hit;

    // A beat transfers on a rising edge where byte_valid_i and byte_ready_o are both high;
    // byte_ready_o is decoded from the state alone, so ACCEPT and DROP take every valid beat.
    assign core_edge = core_valid_i && !valid_prev_q;

    // State register (also holds the datapath flops)
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_ACCEPT;
            count_q      <= '0;
            msg_q        <= '0;
            err_q        <= 1'b0;
            start_cnt_q  <= '0;
            valid_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            msg_q        <= msg_d;
            err_q        <= err_d;
            start_cnt_q  <= start_cnt_d;
            valid_prev_q <= valid_prev_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCEPT: begin
                if (byte_valid_i) begin
                    if (byte_last_i && byte_empty_i) begin
                        state_d = ST_PAD;
                    end else if (count_q == MAX_BYTES) begin
                        state_d = byte_last_i ? ST_CLEAR : ST_DROP;
                    end else if (byte_last_i) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD:   state_d = ST_START;
            ST_START: begin
                if (start_cnt_q == START_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_edge || timeout_hit) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DROP: begin
                if (byte_valid_i && byte_last_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_ACCEPT;
            default:  state_d = ST_ACCEPT;
        endcase
    end

    // Datapath: byte packing, padding and the launch/edge bookkeeping
    always_comb begin
        count_d      = count_q;
        msg_d        = msg_q;
        err_d        = 1'b0;
        start_cnt_d  = start_cnt_q;
        valid_prev_d = core_valid_i;
        case (state_q)
            ST_ACCEPT: begin
                if (byte_valid_i && !(byte_last_i && byte_empty_i)) begin
                    if (count_q == MAX_BYTES) begin
                        err_d = byte_last_i;
                    end else begin
                        for (int i = 0; i < 56; i++) begin
                            if (count_q == 6'(i)) begin
                                msg_d[MSG_W-1-8*i -: 8] = byte_data_i;
                            end
                        end
                        count_d = count_q + 6'd1;
                    end
                end
            end
            ST_PAD: begin
                for (int i = 0; i < 56; i++) begin
                    if (count_q == 6'(i)) begin
                        msg_d[MSG_W-1-8*i -: 8] = 8'h80;
                    end
                end
                msg_d[63:0] = {55'd0, count_q, 3'b000};
                start_cnt_d = '0;
                // A core_valid_i level already high at launch must fall before it can count as done.
                valid_prev_d = 1'b1;
            end
            ST_START: start_cnt_d = start_cnt_q + 4'd1;
            ST_WAIT:  err_d = timeout_hit && !core_edge;
            ST_DROP:  err_d = byte_valid_i && byte_last_i;
            ST_CLEAR: begin
                count_d = '0;
                msg_d   = '0;
            end
            default: ;
        endcase
    end

`ifdef SHA256_PADDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    // Output decode: state register and flops only, no input reaches an output
    always_comb begin
        byte_ready_o = (state_q == ST_ACCEPT) || (state_q == ST_DROP);
        busy_o       = !((state_q == ST_ACCEPT) || (state_q == ST_DROP));
        start_o      = (state_q == ST_START);
    end

    assign msg_o = msg_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_sha256_padder.sv
`timescale 1ns/1ps
// Directed bench for sha256_padder: a scoreboard queue of expected blocks/errors, a monitor
// that pops on each start_o or err_o pulse, and a small core model that answers launches.
module tb_sha256_padder;

    localparam int START_CYCLES = 2;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'd0, 64'h18};
    localparam logic [511:0] EMPTY_BLK = {8'h80, 440'd0, 64'd0};
    localparam logic [511:0] B55_BLK   = {440'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f30313233343536, 8'h80, 64'h1b8};
    localparam logic [511:0] HELLO_BLK = {40'h68656c6c6f, 8'h80, 400'd0, 64'h28};
    localparam logic [511:0] A_BLK     = {8'h61, 8'h80, 432'd0, 64'h8};

    logic         clk_i;
    logic         rstn_i;
    logic         byte_valid_i;
    logic [7:0]   byte_data_i;
    logic         byte_last_i;
    logic         byte_empty_i;
    logic         byte_ready_o;
    logic         start_o;
    logic [511:0] msg_o;
    logic         core_valid_i;
    logic         busy_o;
    logic         err_o;

    int checks = 0;
    int errors = 0;

    // Bit 512 marks an expected err_o pulse; otherwise bits 511:0 are the expected block.
    logic [512:0] exp_q[$];

    // Core model controls
    logic core_auto   = 1'b1;
    int   stale_cycles = 1;

    sha256_padder #(
        .START_CYCLES   (START_CYCLES),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_last_i  (byte_last_i),
        .byte_empty_i (byte_empty_i),
        .byte_ready_o (byte_ready_o),
        .start_o      (start_o),
        .msg_o        (msg_o),
        .core_valid_i (core_valid_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // Clock and watchdog
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Driver: must be entered just after a rising edge; returns at handshake edge + 1.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int guard;
        byte_valid_i = 1'b1;
        byte_data_i  = d;
        byte_last_i  = last;
        byte_empty_i = empty;
        guard = 0;
        @(negedge clk_i);
        while (!byte_ready_o && guard < 300) begin
            @(negedge clk_i);
            guard++;
        end
        if (!byte_ready_o) begin
            check_bit("beat_ready_timeout", byte_ready_o, 1'b1);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_msg(input logic [511:0] b, input int n, input logic keep);
        if (!byte_valid_i) begin
            @(posedge clk_i);
            #1;
        end
        if (n == 0) begin
            send_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int k = 0; k < n; k++) begin
                send_beat(b[511-8*k -: 8], (k == n - 1), 1'b0);
            end
        end
        if (!keep) begin
            byte_valid_i = 1'b0;
            byte_last_i  = 1'b0;
            byte_empty_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk_i);
        while ((!byte_ready_o || busy_o) && guard < 300) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 300) begin
            check_bit("idle_timeout", byte_ready_o, 1'b1);
        end
    endtask

    // Core model: on a launch, keep the old valid level a while, drop it, then raise it.
    logic low_ok;
    initial begin
        forever begin
            @(negedge clk_i);
            if (core_auto && rstn_i && start_o) begin
                low_ok = 1'b1;
                repeat (stale_cycles) begin
                    @(negedge clk_i);
                    low_ok = low_ok && !byte_ready_o && busy_o;
                end
                core_valid_i = 1'b0;
                repeat (3) begin
                    @(negedge clk_i);
                    low_ok = low_ok && !byte_ready_o && busy_o;
                end
                core_valid_i = 1'b1;
                @(negedge clk_i);
                low_ok = low_ok && !byte_ready_o && busy_o;
                check_bit("ready_low_until_clear", low_ok, 1'b1);
                @(negedge clk_i);
                check_bit("turnaround_ready", byte_ready_o, 1'b1);
            end
        end
    end

    // Monitor / scoreboard
    logic         mon_start_prev = 1'b0;
    logic         mon_err_prev   = 1'b0;
    int           mon_start_len  = 0;
    int           mon_err_len    = 0;
    logic [511:0] mon_held       = '0;
    logic         mon_holding    = 1'b0;
    logic         mon_stable     = 1'b1;
    logic [512:0] mon_ev;

    initial begin
        forever begin
            @(negedge clk_i);
            if (start_o && !mon_start_prev) begin
                check_bit("start_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    mon_ev = exp_q.pop_front();
                    check_bit("event_kind_start", mon_ev[512], 1'b0);
                    check_vec("msg_block", msg_o, mon_ev[511:0]);
                end
                mon_held      = msg_o;
                mon_holding   = 1'b1;
                mon_stable    = 1'b1;
                mon_start_len = 0;
            end
            if (start_o) mon_start_len++;
            if (!start_o && mon_start_prev) check_int("start_len", mon_start_len, START_CYCLES);
            if (mon_holding) begin
                if (busy_o) begin
                    if (msg_o !== mon_held) mon_stable = 1'b0;
                end else begin
                    check_bit("msg_stable", mon_stable, 1'b1);
                    mon_holding = 1'b0;
                end
            end
            if (err_o && !mon_err_prev) begin
                check_bit("err_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    mon_ev = exp_q.pop_front();
                    check_bit("event_kind_err", mon_ev[512], 1'b1);
                end
                mon_err_len = 0;
            end
            if (err_o) mon_err_len++;
            if (!err_o && mon_err_prev) check_int("err_len", mon_err_len, 1);
            mon_start_prev = start_o;
            mon_err_prev   = err_o;
        end
    end

    // Stimulus
    logic [511:0] in_buf;
    int idx, wait_idx, err_idx;
    logic seen_start;

    initial begin
        rstn_i       = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        byte_last_i  = 1'b0;
        byte_empty_i = 1'b0;
        core_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_bit("reset_ready", byte_ready_o, 1'b1);
        check_bit("reset_busy", busy_o, 1'b0);
        check_bit("reset_start", start_o, 1'b0);
        check_bit("reset_err", err_o, 1'b0);
        check_vec("reset_msg", msg_o, 512'd0);
        rstn_i = 1'b1;

        // "abc" with latency checks
        in_buf = {24'h616263, 488'd0};
        exp_q.push_back({1'b0, ABC_BLK});
        send_msg(in_buf, 3, 1'b0);
        @(negedge clk_i);
        check_bit("pad_start_low", start_o, 1'b0);
        check_bit("pad_ready_low", byte_ready_o, 1'b0);
        @(negedge clk_i);
        check_bit("start_latency", start_o, 1'b1);
        check_vec("abc_msg_at_start", msg_o, ABC_BLK);
        wait_idle();

        // Empty message
        exp_q.push_back({1'b0, EMPTY_BLK});
        send_msg(512'd0, 0, 1'b0);
        wait_idle();

        // 55-byte message: largest that fits
        in_buf = '0;
        for (int k = 0; k < 55; k++) in_buf[511-8*k -: 8] = 8'(k);
        exp_q.push_back({1'b0, B55_BLK});
        send_msg(in_buf, 55, 1'b0);
        wait_idle();

        // 56-byte message: rejected on its last beat
        for (int k = 0; k < 60; k++) in_buf[511-8*k -: 8] = 8'(k);
        exp_q.push_back({1'b1, 512'd0});
        send_msg(in_buf, 56, 1'b0);
        @(negedge clk_i);
        check_bit("ovl56_err_pulse", err_o, 1'b1);
        check_bit("ovl56_ready_low", byte_ready_o, 1'b0);
        @(negedge clk_i);
        check_bit("ovl56_err_clear", err_o, 1'b0);
        check_bit("ovl56_ready_back", byte_ready_o, 1'b1);
        check_vec("ovl56_msg_cleared", msg_o, 512'd0);

        // 60-byte message: drained through DROP
        exp_q.push_back({1'b1, 512'd0});
        send_msg(in_buf, 60, 1'b0);
        @(negedge clk_i);
        check_bit("ovl60_err_pulse", err_o, 1'b1);
        @(negedge clk_i);
        check_bit("ovl60_err_clear", err_o, 1'b0);
        check_bit("ovl60_ready_back", byte_ready_o, 1'b1);

        // Back-to-back with valid held and a stale core valid level
        stale_cycles = 5;
        in_buf = {40'h68656c6c6f, 472'd0};
        exp_q.push_back({1'b0, HELLO_BLK});
        exp_q.push_back({1'b0, A_BLK});
        send_msg(in_buf, 5, 1'b1);
        in_buf = {8'h61, 504'd0};
        send_msg(in_buf, 1, 1'b0);
        wait_idle();
        stale_cycles = 1;

        // Reset while in WAIT
        core_auto = 1'b0;
        in_buf = {24'h616263, 488'd0};
        exp_q.push_back({1'b0, ABC_BLK});
        send_msg(in_buf, 3, 1'b0);
        seen_start = 1'b0;
        idx = 0;
        while (idx < 40 && !(seen_start && !start_o)) begin
            @(negedge clk_i);
            if (start_o) seen_start = 1'b1;
            idx++;
        end
        check_bit("rst_wait_reached", busy_o, 1'b1);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        check_bit("rst_wait_busy", busy_o, 1'b0);
        check_bit("rst_wait_start", start_o, 1'b0);
        check_bit("rst_wait_err", err_o, 1'b0);
        check_bit("rst_wait_ready", byte_ready_o, 1'b1);
        check_vec("rst_wait_msg", msg_o, 512'd0);
        rstn_i = 1'b1;

`ifdef SHA256_PADDER_TIMEOUT_EN
        // Watchdog: core never answers
        exp_q.push_back({1'b0, ABC_BLK});
        exp_q.push_back({1'b1, 512'd0});
        send_msg(in_buf, 3, 1'b0);
        idx = 0;
        wait_idx = -1;
        err_idx = -1;
        seen_start = 1'b0;
        while (idx < 80 && err_idx < 0) begin
            @(negedge clk_i);
            if (start_o) seen_start = 1'b1;
            else if (seen_start && wait_idx < 0) wait_idx = idx;
            if (err_o) err_idx = idx;
            idx++;
        end
        check_int("timeout_delay", err_idx - wait_idx, 16);
        @(negedge clk_i);
        check_bit("timeout_ready_back", byte_ready_o, 1'b1);
`endif

        repeat (4) @(negedge clk_i);
        check_int("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
